// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the default tick convention
// used by both the oversampling receiver and the transmitter.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx_os.sv
// UART transmitter, LSB first, paced by an external oversample strobe.
// A one-entry holding register lets the host queue the next byte so that
// consecutive frames leave the pad with no idle bit between them.
module uart_tx_os
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_enb,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 tx
);

   localparam int unsigned STOP_TICKS = STOP_BITS * OVERSAMPLE;
   localparam int unsigned TW = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
   localparam logic          ODD_SEL   = 1'(PARITY_ODD);

   uart_state_e          state_q;
   logic [TW-1:0]        tick_q;
   logic [BW-1:0]        bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] hold_data_q;
   logic                 hold_valid_q;
   logic                 tx_q;
   logic                 done_q;

   logic [BW-1:0]        bit_nxt;
   logic                 parity_bit;

   assign bit_nxt    = bit_idx_q + BW'(1);
   assign parity_bit = (^shift_q) ^ ODD_SEL;

   // Host write path, strobe-paced frame sequencer and registered line driver
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Accepted on any cycle; a full holding register silently drops the write
         if (wr_en && !hold_valid_q) begin
            hold_data_q  <= data_in;
            hold_valid_q <= 1'b1;
         end

         if (tx_enb) begin
            unique case (state_q)
               ST_IDLE: begin
                  tx_q <= 1'b1;
                  if (hold_valid_q) begin
                     shift_q      <= hold_data_q;
                     hold_valid_q <= 1'b0;
                     tx_q         <= 1'b0;
                     tick_q       <= '0;
                     state_q      <= ST_START;
                  end
               end
               ST_START: begin
                  if (tick_q == BIT_LAST) begin
                     tick_q    <= '0;
                     bit_idx_q <= '0;
                     tx_q      <= shift_q[0];
                     state_q   <= ST_DATA;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               ST_DATA: begin
                  if (tick_q == BIT_LAST) begin
                     tick_q <= '0;
                     if (bit_idx_q != IDX_LAST) begin
                        bit_idx_q <= bit_nxt;
                        tx_q      <= shift_q[bit_nxt];
                     end else if (PARITY_EN != 0) begin
                        tx_q    <= parity_bit;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               ST_PARITY: begin
                  if (tick_q == BIT_LAST) begin
                     tick_q  <= '0;
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               ST_STOP: begin
                  if (tick_q == STOP_LAST) begin
                     tick_q <= '0;
                     done_q <= 1'b1;
                     // Chain straight into the next start bit when a byte is waiting
                     if (hold_valid_q) begin
                        shift_q      <= hold_data_q;
                        hold_valid_q <= 1'b0;
                        tx_q         <= 1'b0;
                        state_q      <= ST_START;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               default: begin
                  tick_q  <= '0;
                  tx_q    <= 1'b1;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ready = ~hold_valid_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = done_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_os.sv
// Bench for uart_tx_os: a default 8N1 instance and an 8O2 instance share the
// same stimulus. Each is checked every clock against a frame-level model that
// predicts the line level from (ticks since load / ticks per bit).
module tb_uart_tx_os;

   localparam int unsigned OS = 16;

   logic       clk;
   logic       reset;
   logic       tx_enb;
   logic       wr_en;
   logic [7:0] data_in;
   logic [1:0] ready_w;
   logic [1:0] busy_w;
   logic [1:0] done_w;
   logic [1:0] tx_w;

   int vectors;
   int errs;

   // Reference model state, one slot per instance
   int         pos   [2];
   int         nbits [2];
   logic [11:0] fbits [2];
   logic       hv    [2];
   logic [7:0] hd    [2];
   logic       inf   [2];
   logic       etx   [2];
   logic       edone [2];

   uart_tx_os u_dut (
      .clk     (clk),
      .reset   (reset),
      .tx_enb  (tx_enb),
      .wr_en   (wr_en),
      .data_in (data_in),
      .ready   (ready_w[0]),
      .busy    (busy_w[0]),
      .done    (done_w[0]),
      .tx      (tx_w[0])
   );

   uart_tx_os #(
      .STOP_BITS  (2),
      .PARITY_EN  (1),
      .PARITY_ODD (1)
   ) u_dut_p (
      .clk     (clk),
      .reset   (reset),
      .tx_enb  (tx_enb),
      .wr_en   (wr_en),
      .data_in (data_in),
      .ready   (ready_w[1]),
      .busy    (busy_w[1]),
      .done    (done_w[1]),
      .tx      (tx_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build the bit sequence of one frame: start, data LSB first, parity, stops
   task automatic load_frame(input int u, input logic [7:0] b);
      int n;
      fbits[u] = '1;
      fbits[u][0] = 1'b0;
      for (int i = 0; i < 8; i++) fbits[u][1 + i] = b[i];
      n = 9;
      if (u == 1) begin
         fbits[u][9] = (^b) ^ 1'b1;
         n = n + 1 + 2;
      end else begin
         n = n + 1;
      end
      nbits[u] = n;
      pos[u]   = 0;
      inf[u]   = 1'b1;
   endtask

   // Advance the model by one clock given the inputs seen at that edge
   task automatic model_edge(input int u, input logic r, input logic w,
                             input logic [7:0] d, input logic e);
      logic old_hv;
      if (r) begin
         hv[u] = 1'b0; inf[u] = 1'b0; pos[u] = 0;
         etx[u] = 1'b1; edone[u] = 1'b0;
         return;
      end
      edone[u] = 1'b0;
      old_hv   = hv[u];
      if (e) begin
         if (inf[u] && pos[u] == nbits[u] * OS) begin
            edone[u] = 1'b1;
            inf[u]   = 1'b0;
         end
         if (!inf[u] && hv[u]) begin
            load_frame(u, hd[u]);
            hv[u] = 1'b0;
         end
         if (inf[u]) begin
            etx[u] = fbits[u][pos[u] / OS];
            pos[u] = pos[u] + 1;
         end else begin
            etx[u] = 1'b1;
         end
      end
      if (w && !old_hv) begin
         hv[u] = 1'b1;
         hd[u] = d;
      end
   endtask

   task automatic chk(input string tag, input int u, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s[%0d] t=%0t: observed %b expected %b", tag, u, $time, obs, exp);
      end
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare
   task automatic step(input logic r, input logic w, input logic [7:0] d, input logic e);
      reset = r; wr_en = w; data_in = d; tx_enb = e;
      @(posedge clk);
      for (int u = 0; u < 2; u++) model_edge(u, r, w, d, e);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("tx",    u, tx_w[u],    etx[u]);
         chk("done",  u, done_w[u],  edone[u]);
         chk("busy",  u, busy_w[u],  inf[u]);
         chk("ready", u, ready_w[u], ~hv[u]);
      end
   endtask

   task automatic idle_run(input int n, input int div);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, (k % div) == 0);
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      for (int u = 0; u < 2; u++) begin
         pos[u] = 0; nbits[u] = 10; fbits[u] = '1; hv[u] = 1'b0; hd[u] = '0;
         inf[u] = 1'b0; etx[u] = 1'b1; edone[u] = 1'b0;
      end
      reset = 1'b1; wr_en = 1'b0; data_in = '0; tx_enb = 1'b0;

      // Reset, then a single 0xA5 frame with a strobe every clock
      step(1'b1, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      idle_run(3, 1);
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      idle_run(220, 1);

      // 0x3C, then 0xF0 during its start bit, then a write that must be dropped
      step(1'b0, 1'b1, 8'h3C, 1'b1);
      idle_run(4, 1);
      step(1'b0, 1'b1, 8'hF0, 1'b1);
      idle_run(3, 1);
      step(1'b0, 1'b1, 8'h99, 1'b1);
      idle_run(450, 1);

      // Slow strobe: one tick every 4 clocks, all-zero byte
      step(1'b0, 1'b1, 8'h00, 1'b0);
      idle_run(4 * 200, 4);

      // 0x07 on both instances (parity instance: odd parity bit 0, two stops)
      step(1'b0, 1'b1, 8'h07, 1'b0);
      idle_run(210, 1);

      // Reset mid-frame with a byte waiting in the holding register
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      idle_run(20, 1);
      step(1'b0, 1'b1, 8'h5A, 1'b1);
      idle_run(30, 1);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      idle_run(300, 1);

      // Random traffic, random strobe spacing, occasional reset
      for (int k = 0; k < 4000; k++) begin
         step(($urandom_range(0, 999) == 0),
              ($urandom_range(0, 7) == 0),
              8'($urandom),
              ($urandom_range(0, 2) == 0));
      end
      idle_run(1200, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/uart_tx_os.md
Name: uart_tx_os

Overview:
- 8-bit UART transmitter, LSB first, timed by an external 16x-oversample strobe `tx_enb`.
- It is the transmit end of the same serial link served by our oversampling receiver, and uses the same tick convention: one bit = OVERSAMPLE `tx_enb` ticks.
- A one-entry holding register lets the host queue the next byte while the current frame shifts out, so back-to-back frames go out with no idle gap.
- Sits between the host/bus write interface and the `tx` pad.

Parameters:
- OVERSAMPLE, 16, `tx_enb` ticks per serial bit (must be ≥2).
- DATA_BITS, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- tx_enb  input  1  oversample strobe, one clk cycle wide, OVERSAMPLE strobes per bit.
- wr_en  input  1  host write request.
- data_in  input  DATA_BITS  byte to transmit; sampled when `wr_en && ready`.
- ready  output  1  holding register empty; a write is accepted this cycle.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-clk pulse at the end of each frame's last stop bit.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (any cycle, including mid-frame): at the next clk edge `tx`=1, `ready`=1, `busy`=0, `done`=0, state=IDLE, tick_cnt=0, bit_idx=0, holding register emptied. A partial frame is abandoned.
- Write handshake:
  - `wr_en && ready` in cycle N → hold_data=data_in, hold_valid=1; `ready`=0 from cycle N+1.
  - `wr_en && !ready` → ignored; hold_data is unchanged and no error is flagged.
  - Writes are accepted on any clk cycle, independent of `tx_enb`.
- `ready` = !hold_valid, taken from the register.
- FSM states: IDLE, START, DATA, PARITY, STOP. State, counters and `tx` change only in cycles with `tx_enb`=1. With `tx_enb`=0 everything is frozen except the write path and the `done` clear.
- IDLE:
  - `tx`=1.
  - On `tx_enb` with hold_valid=1: shift_reg←hold_data, hold_valid←0, `tx`←0, tick_cnt←0, state←START.
  - Load uses hold_valid from before the current edge, so a byte written in the same cycle is loaded at the next `tx_enb`.
- START: holds `tx`=0 for OVERSAMPLE ticks. On tick_cnt==OVERSAMPLE-1: tick_cnt←0, bit_idx←0, `tx`←shift_reg[0], state←DATA.
- DATA:
  - Each bit is held for OVERSAMPLE ticks.
  - At the end of a bit with bit_idx<DATA_BITS-1: bit_idx+1, drive next bit.
  - At the end of the last bit: go to PARITY (if PARITY_EN) driving XOR(data)^PARITY_ODD, else to STOP driving 1.
- PARITY: OVERSAMPLE ticks, then STOP with `tx`=1.
- STOP:
  - `tx`=1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick: `done`=1 for exactly one clk cycle.
  - If hold_valid=1 on that tick, load the held byte and go directly to START with `tx`←0 (no idle bit). Otherwise go to IDLE.
- `done` is cleared on the next clk edge regardless of `tx_enb`.
- Counters: tick_cnt is wide enough for STOP_BITS*OVERSAMPLE-1 and wraps to 0 on every state exit; bit_idx is clog2(DATA_BITS) wide.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × OVERSAMPLE ticks. Defaults give 160 ticks.
- Latency: with IDLE and empty hold, a write in cycle N makes `tx` fall at the edge of the first `tx_enb` cycle after N.
- `tx` is a registered output with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding constants (IDLE/START/DATA/PARITY/STOP).
  - Default OVERSAMPLE=16 and DATA_BITS=8, shared with the receiver so both ends agree on the tick convention.
- No sub-module is required. The baud/oversample strobe generator (uart_baud_gen) is a separate, existing-style block instantiated at the top level, not inside this module.

Test Plan:
1. Reset, `tx_enb` every clk, write 0xA5 → `tx` reads 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each level held 16 clks; `done` pulses once at clk 160; `busy` falls next cycle; `ready` back to 1 at load.
2. Write 0x3C, then write 0xF0 during the start bit, then a third write while `ready`=0 → third is ignored; 0x3C and 0xF0 go out back-to-back with zero idle ticks; two `done` pulses 160 ticks apart.
3. `tx_enb` once every 4 clks, write 0x00 → every bit lasts 64 clks; `tx` never changes on non-strobe cycles.
4. PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, write 0x07 → parity bit=0; stop high for 32 ticks; frame totals 192 ticks.
5. Assert reset at tick 50 of a 0xFF frame with a byte held → `tx`=1, `ready`=1, `busy`=0 next edge; no `done`; the held byte is never sent.
6. Loopback: connect `tx` to our receiver sharing the same strobe, send 0x00, 0xFF, 0x55, 0x81 → the receiver's `rdy` pulses four times with identical `data_out` values.
